// File: rtl/gate_chk_pkg.sv
// Shared types and truth-table constants for the 2-input gate checker.
// Truth tables are indexed by the vector {b,a}.
package gate_chk_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef logic [1:0] vec_idx_t;

   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_XNOR = 4'b1001;

   // Expected gate output for one input vector.
   function automatic logic tt_expect(input logic [3:0] tt, input vec_idx_t idx);
      return tt[idx];
   endfunction

endpackage

// File: rtl/gate_chk_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module gate_chk_sat_cnt #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
   localparam logic [W-1:0] CNT_ONE = W'(1'b1);

   logic [W-1:0] cnt_r;

   // Count register: clear, saturating increment, else hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {W{1'b0}};
      end else if (clr) begin
         cnt_r <= {W{1'b0}};
      end else if (inc && (cnt_r != CNT_MAX)) begin
         cnt_r <= cnt_r + CNT_ONE;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign cnt = cnt_r;

endmodule

// File: rtl/gate2_checker.sv
// Stimulus generator and response checker for a 2-input combinational gate:
// sweeps {b,a} = 0..3, lets each vector settle, then compares y against a truth table.
module gate2_checker
   import gate_chk_pkg::*;
#(
   parameter logic [3:0] TRUTH_TABLE   = TT_AND,
   parameter int         SETTLE_CYCLES = 1,
   parameter int         N_SWEEPS      = 1,
   parameter int         ERR_W         = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             y_i,
   output logic             a_o,
   output logic             b_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic [ERR_W-1:0] err_cnt_o,
   output logic [3:0]       fail_vec_o
);

   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int SWP_W = (N_SWEEPS > 1) ? $clog2(N_SWEEPS) : 1;
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [SWP_W-1:0] SWEEP_LAST  = SWP_W'(N_SWEEPS - 1);
   localparam logic [SET_W-1:0] SET_ONE     = SET_W'(1'b1);
   localparam logic [SWP_W-1:0] SWP_ONE     = SWP_W'(1'b1);

   state_e           state_r, state_s;
   vec_idx_t         idx_r, idx_s;
   logic [SET_W-1:0] settle_r, settle_s;
   logic [SWP_W-1:0] sweep_r, sweep_s;
   logic             a_r, a_s, b_r, b_s;
   logic             busy_r, busy_s, done_r, done_s, pass_r, pass_s;
   logic [3:0]       fail_vec_r, fail_vec_s;
   logic             mismatch_s, clr_s, inc_s;
   logic [ERR_W-1:0] err_cnt_s;

   gate_chk_sat_cnt #(.W(ERR_W)) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_s),
      .inc   (inc_s),
      .cnt   (err_cnt_s)
   );

   assign mismatch_s = (y_i != tt_expect(TRUTH_TABLE, idx_r));

   // Next-state and next-output logic; outputs are computed one edge ahead and registered.
   always_comb begin
      state_s    = state_r;
      idx_s      = idx_r;
      settle_s   = settle_r;
      sweep_s    = sweep_r;
      a_s        = a_r;
      b_s        = b_r;
      busy_s     = busy_r;
      done_s     = 1'b0;
      pass_s     = pass_r;
      fail_vec_s = fail_vec_r;
      clr_s      = 1'b0;
      inc_s      = 1'b0;
      case (state_r)
         IDLE: begin
            a_s    = 1'b0;
            b_s    = 1'b0;
            busy_s = 1'b0;
            if (start_i) begin
               state_s    = APPLY;
               idx_s      = 2'd0;
               sweep_s    = {SWP_W{1'b0}};
               settle_s   = {SET_W{1'b0}};
               clr_s      = 1'b1;
               pass_s     = 1'b0;
               fail_vec_s = 4'b0000;
               busy_s     = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         APPLY: begin
            a_s = idx_r[0];
            b_s = idx_r[1];
            if (settle_r == SETTLE_LAST) begin
               state_s = CHECK;
            end else begin
               settle_s = settle_r + SET_ONE;
            end
         end
         CHECK: begin
            inc_s = mismatch_s;
            if (mismatch_s) begin
               fail_vec_s[idx_r] = 1'b1;
            end else begin
               fail_vec_s = fail_vec_r;
            end
            if ((idx_r == 2'd3) && (sweep_r == SWEEP_LAST)) begin
               state_s = DONE;
               done_s  = 1'b1;
               // The counter has not yet absorbed this cycle's result, and it never wraps.
               pass_s  = (err_cnt_s == {ERR_W{1'b0}}) && !mismatch_s;
            end else begin
               state_s  = APPLY;
               idx_s    = idx_r + 2'd1;
               settle_s = {SET_W{1'b0}};
               if (idx_r == 2'd3) begin
                  sweep_s = sweep_r + SWP_ONE;
               end else begin
                  sweep_s = sweep_r;
               end
               a_s = idx_s[0];
               b_s = idx_s[1];
            end
         end
         DONE: begin
            state_s = IDLE;
            busy_s  = 1'b0;
            a_s     = 1'b0;
            b_s     = 1'b0;
         end
         default: begin
            state_s = IDLE;
            busy_s  = 1'b0;
            a_s     = 1'b0;
            b_s     = 1'b0;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         idx_r      <= 2'd0;
         settle_r   <= {SET_W{1'b0}};
         sweep_r    <= {SWP_W{1'b0}};
         a_r        <= 1'b0;
         b_r        <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         pass_r     <= 1'b0;
         fail_vec_r <= 4'b0000;
      end else begin
         state_r    <= state_s;
         idx_r      <= idx_s;
         settle_r   <= settle_s;
         sweep_r    <= sweep_s;
         a_r        <= a_s;
         b_r        <= b_s;
         busy_r     <= busy_s;
         done_r     <= done_s;
         pass_r     <= pass_s;
         fail_vec_r <= fail_vec_s;
      end
   end

   assign a_o        = a_r;
   assign b_o        = b_r;
   assign busy_o     = busy_r;
   assign done_o     = done_r;
   assign pass_o     = pass_r;
   assign err_cnt_o  = err_cnt_s;
   assign fail_vec_o = fail_vec_r;

endmodule
